axi4_stream_arbiter_rr: RTL and testbench

Packet-level round-robin arbiter that shares one AXI4-Stream master among PORTS_AMOUNT slave streams. A grant is held from a packet's first beat until its tlast beat, so packets are never interleaved. The output goes through a one-beat registered stage. The block sits in front of a shared downstream consumer such as a DMA, MAC or FIFO, which attaches to pkt_o.

---
 rtl/axi4_stream_arbiter_rr_if.sv | 28 ++
 rtl/axi4_stream_arbiter_rr.sv | 137 +++++++++++++
 tb/tb_axi4_stream_arbiter_rr.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_arbiter_rr_if.sv
// AXI4-Stream signal bundle used on both the requesting and the shared side
// of axi4_stream_arbiter_rr.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) ();
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tstrb;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic [TID_WIDTH-1:0]       tid;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TUSER_WIDTH-1:0]     tuser;

  modport master (
    output tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_arbiter_rr.sv
// Packet-level round-robin arbiter feeding one registered AXI4-Stream output.
// Define AXI4_STREAM_ARB_TID_OVERRIDE_EN to drive pkt_o.tid with the granted port index.
module axi4_stream_arbiter_rr #(
  parameter int TDATA_WIDTH  = 32,
  parameter int TID_WIDTH    = 1,
  parameter int TDEST_WIDTH  = 1,
  parameter int TUSER_WIDTH  = 1,
  parameter int PORTS_AMOUNT = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  axi4_stream_if.slave  pkt_i [PORTS_AMOUNT],
  axi4_stream_if.master pkt_o
);
  localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;
  localparam int GRANT_WIDTH = $clog2(PORTS_AMOUNT);

  typedef logic [GRANT_WIDTH-1:0] port_idx_t;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef struct packed {
    logic                   last;
    logic [TDATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0]  strb;
    logic [KEEP_WIDTH-1:0]  keep;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TUSER_WIDTH-1:0] user;
  } beat_t;

`ifdef AXI4_STREAM_ARB_TID_OVERRIDE_EN
  if (TID_WIDTH < $clog2(PORTS_AMOUNT)) begin : g_tid_width_check
    $error("TID_WIDTH too narrow to carry the granted port index");
  end
`endif

  state_t                  state, state_next;
  port_idx_t               grant, grant_next;
  port_idx_t               last_grant, last_grant_next;
  port_idx_t               pick, cand;
  logic                    found;
  logic [PORTS_AMOUNT-1:0] req_valid, req_ready;
  beat_t                   req_beat [PORTS_AMOUNT];
  beat_t                   sel_beat, out_beat;
  logic                    out_valid;
  logic                    load, accept;

  for (genvar n = 0; n < PORTS_AMOUNT; n++) begin : g_port
    assign req_valid[n]    = pkt_i[n].tvalid;
    assign req_beat[n]     = {pkt_i[n].tlast, pkt_i[n].tdata, pkt_i[n].tstrb, pkt_i[n].tkeep,
                              pkt_i[n].tid, pkt_i[n].tdest, pkt_i[n].tuser};
    assign pkt_i[n].tready = req_ready[n];
  end

  // The output register may take a new beat when empty or being drained this cycle.
  assign load = pkt_o.tready || !out_valid;

  // Search starts just after the previous winner and wraps, so each port waits at most one round.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= PORTS_AMOUNT; i++) begin
      cand = port_idx_t'((int'(last_grant) + i) % PORTS_AMOUNT);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    req_ready       = '0;
    accept          = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_next = GRANT;
          grant_next = pick;
        end
      end
      GRANT: begin
        req_ready[grant] = load;
        accept           = req_valid[grant] && load;
        if (accept && req_beat[grant].last) begin
          state_next      = IDLE;
          last_grant_next = grant;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_beat = req_beat[grant];
`ifdef AXI4_STREAM_ARB_TID_OVERRIDE_EN
    sel_beat.id = TID_WIDTH'(grant);
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= port_idx_t'(PORTS_AMOUNT - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_beat  <= sel_beat;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tlast  = out_beat.last;
  assign pkt_o.tdata  = out_beat.data;
  assign pkt_o.tstrb  = out_beat.strb;
  assign pkt_o.tkeep  = out_beat.keep;
  assign pkt_o.tid    = out_beat.id;
  assign pkt_o.tdest  = out_beat.dest;
  assign pkt_o.tuser  = out_beat.user;
endmodule

// File: tb/tb_axi4_stream_arbiter_rr.sv
// Randomized scoreboard bench for axi4_stream_arbiter_rr with a packet-level round-robin model.
// Honours AXI4_STREAM_ARB_TID_OVERRIDE_EN when computing expected tid.
module tb_axi4_stream_arbiter_rr;
  localparam int PORTS = 4;
  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int IW    = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          dest;
    logic          user;
    logic          last;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) in_if [PORTS] ();
  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) out_if ();

  axi4_stream_arbiter_rr #(
    .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .PORTS_AMOUNT(PORTS)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pkt_i(in_if),
    .pkt_o(out_if)
  );

  logic [PORTS-1:0] drv_valid;
  logic [PORTS-1:0] in_ready;
  beat_t            drv_beat [PORTS];
  logic             o_ready = 1'b1;
  bit               rand_ready = 1'b0;

  beat_t port_q [PORTS][$];
  int    gap_q  [PORTS][$];
  beat_t exp_q  [PORTS][$];
  int    model_last = PORTS - 1;
  int    cur_port   = -1;
  int    fire_cyc [$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  for (genvar g = 0; g < PORTS; g++) begin : g_drv
    assign in_if[g].tvalid = drv_valid[g];
    assign in_if[g].tdata  = drv_beat[g].data;
    assign in_if[g].tstrb  = drv_beat[g].strb;
    assign in_if[g].tkeep  = drv_beat[g].keep;
    assign in_if[g].tid    = drv_beat[g].id;
    assign in_if[g].tdest  = drv_beat[g].dest;
    assign in_if[g].tuser  = drv_beat[g].user;
    assign in_if[g].tlast  = drv_beat[g].last;
    assign in_ready[g]     = in_if[g].tready;
  end
  assign out_if.tready = o_ready;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin at packet granularity: next owner is the first port after the last winner with a queued packet.
  function automatic int next_port();
    for (int i = 1; i <= PORTS; i++) begin
      int p;
      p = (model_last + i) % PORTS;
      if (exp_q[p].size() > 0) return p;
    end
    return -1;
  endfunction

  function automatic bit busy();
    busy = out_if.tvalid;
    for (int p = 0; p < PORTS; p++)
      if (port_q[p].size() > 0 || exp_q[p].size() > 0) busy = 1'b1;
  endfunction

  task automatic send_pkt(input int p, input int len, input bit seq, input logic [DW-1:0] base,
                          input int gap_at, input int gap_len, input int max_gap, input int tid);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      beat_t e;
      int    g;
      b.data = seq ? base + DW'(i) : DW'($urandom);
      b.strb = KW'($urandom);
      b.keep = KW'($urandom);
      b.id   = (tid >= 0) ? IW'(tid) : IW'($urandom);
      b.dest = 1'($urandom);
      b.user = 1'($urandom);
      b.last = (i == len - 1);
      g = (i == gap_at) ? gap_len : 0;
      if (max_gap > 0) g += $urandom_range(0, max_gap);
      if (i == 0) g = 0;
      port_q[p].push_back(b);
      gap_q[p].push_back(g);
      e = b;
`ifdef AXI4_STREAM_ARB_TID_OVERRIDE_EN
      e.id = IW'(p);
`endif
      exp_q[p].push_back(e);
    end
  endtask

  task automatic flush();
    for (int p = 0; p < PORTS; p++) begin
      port_q[p].delete();
      gap_q[p].delete();
      exp_q[p].delete();
      drv_valid[p] = 1'b0;
    end
    cur_port   = -1;
    model_last = PORTS - 1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    check({name, "_drain"}, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge clk_i);
  endtask

  // Per-port sources: present the queued head beat, honouring inter-beat gaps.
  initial begin : driver
    logic [PORTS-1:0] acc;
    forever begin
      @(negedge clk_i);
      acc = drv_valid & in_ready;
      @(posedge clk_i);
      #1;
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int p = 0; p < PORTS; p++) begin
        if (!rst_i && acc[p]) begin
          drv_valid[p] = 1'b0;
          if (port_q[p].size() > 0) begin
            void'(port_q[p].pop_front());
            void'(gap_q[p].pop_front());
          end
        end
        if (!drv_valid[p] && port_q[p].size() > 0) begin
          if (gap_q[p][0] > 0) gap_q[p][0] = gap_q[p][0] - 1;
          else begin
            drv_beat[p]  = port_q[p][0];
            drv_valid[p] = 1'b1;
          end
        end
      end
    end
  end

  initial begin : monitor
    beat_t act;
    beat_t held;
    beat_t e;
    bit    stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk_i);
      act = {out_if.tdata, out_if.tstrb, out_if.tkeep, out_if.tid, out_if.tdest, out_if.tuser, out_if.tlast};
      if (rst_i) stall = 1'b0;
      else begin
        if (stall) check("hold_stable", {out_if.tvalid, act}, {1'b1, held});
        if (out_if.tvalid && out_if.tready) begin
          fire_cyc.push_back(cyc);
          if (cur_port < 0) cur_port = next_port();
          if (cur_port < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected no beat (cycle %0d)", act, cyc);
          end else begin
            e = exp_q[cur_port].pop_front();
            check($sformatf("beat_port%0d", cur_port), 64'(act), 64'(e));
            if (e.last) begin
              model_last = cur_port;
              cur_port   = -1;
            end
          end
        end
        stall = out_if.tvalid && !out_if.tready;
        held  = act;
      end
    end
  end

  initial begin : main
    int n;
    int bad;
    drv_valid = '0;
    for (int p = 0; p < PORTS; p++) drv_beat[p] = '0;
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_out_valid", 64'(out_if.tvalid), 64'd0);
    check("rst_out_data", 64'(out_if.tdata), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);

    // All ports stream 1-beat packets from reset release.
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < PORTS; p++) send_pkt(p, 1, 1'b0, '0, -1, 0, 0, -1);
    repeat (2) @(posedge clk_i);
    fire_cyc.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #2;
    check("lat_edge0_valid", 64'(out_if.tvalid), 64'd0);
    @(posedge clk_i); #2;
    check("lat_edge1_valid", 64'(out_if.tvalid), 64'd1);
    wait_drain("rr_single");
    check("rr_single_count", 64'(fire_cyc.size()), 64'd12);
    for (int i = 1; i < fire_cyc.size(); i++)
      check("rr_single_spacing", 64'(fire_cyc[i] - fire_cyc[i-1]), 64'd2);

    // Port 2 long packet; port 0 joins mid-packet and must wait for tlast plus one bubble.
    fire_cyc.delete();
    send_pkt(2, 5, 1'b1, 32'h10, -1, 0, 0, -1);
    n = 0;
    while (port_q[2].size() > 3 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("late_req_wait", 64'(n < 200), 64'd1);
    send_pkt(0, 1, 1'b0, '0, -1, 0, 0, -1);
    wait_drain("late_req");
    check("late_req_count", 64'(fire_cyc.size()), 64'd6);
    for (int i = 1; i < fire_cyc.size(); i++)
      check("late_req_spacing", 64'(fire_cyc[i] - fire_cyc[i-1]), (i < 5) ? 64'd1 : 64'd2);

    // 16-beat packet under random output backpressure.
    rand_ready = 1'b1;
    send_pkt(1, 16, 1'b0, '0, -1, 0, 0, -1);
    wait_drain("bp_long");

    // Random packets on random ports with random gaps and backpressure.
    for (int k = 0; k < 24; k++)
      send_pkt($urandom_range(0, PORTS - 1), $urandom_range(1, 6), 1'b0, '0, -1, 0, 2, -1);
    wait_drain("random");
    rand_ready = 1'b0;

    // Reset during beat 3 of an 8-beat packet.
    fire_cyc.delete();
    send_pkt(1, 8, 1'b1, 32'h80, -1, 0, 0, -1);
    n = 0;
    while (fire_cyc.size() < 2 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_mid_wait", 64'(n < 200), 64'd1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_if.tvalid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    flush();

    // After release, port 0 wins first and holds the grant through its tvalid gap.
    send_pkt(0, 6, 1'b1, 32'h40, 3, 3, 0, -1);
    send_pkt(1, 2, 1'b1, 32'h50, -1, 0, 0, -1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    n   = 0;
    bad = 0;
    while (port_q[0].size() > 0 && n < 300) begin
      @(negedge clk_i);
      if (in_ready[1]) bad++;
      n++;
    end
    check("gap_hold_wait", 64'(n < 300), 64'd1);
    check("gap_hold_p1_ready", 64'(bad), 64'd0);
    wait_drain("gap_hold");

    // Port 3 sends tid 0; the beat check compares against the override or pass-through value.
    send_pkt(3, 1, 1'b0, '0, -1, 0, 0, 0);
    wait_drain("tid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
